fpu_arbiter: RTL

- Shares one FPU add/sub datapath between NUM_REQ requesters.
- Selects requests round-robin and latches the operands.
- Clears the FPU before each operation by pulsing its active-low reset, then drives the operands and waits for completion.
- Returns the result, status and requester id over a valid/ready response channel, with a timeout guard.
- Sits between the FPU datapath and its clients, e.g. the core issue stage and the DMA post-processing unit.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_rr_arbiter.sv | 43 ++++
 rtl/fpu_arbiter.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// ---------------------------------------------------------------------------
// fpu_pkg
//   Shared definitions for the FPU arbiter slice.
//   - Result-word field positions (sign / biased exponent / mantissa).
//   - FPU status codes as reported on fpu_status_in (bit0 = done).
//   - Controller FSM state type.
// ---------------------------------------------------------------------------
package fpu_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 25;
    localparam int MANT_W   = 25;
    localparam int BIAS     = 31;

    localparam logic [3:0] ST_EXACT   = 4'b0001;
    localparam logic [3:0] ST_INEXACT = 4'b1111;
    localparam logic [3:0] ST_OVF     = 4'b0011;
    localparam logic [3:0] ST_UNF     = 4'b0111;
    localparam logic [3:0] ST_NONE    = 4'b0000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        SETTLE,
        RESP
    } arb_state_t;

endpackage

// File: rtl/fpu_rr_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_rr_arbiter
//   Combinational round-robin grant selection. The search starts at the
//   index after i_rr_ptr and wraps around; the first set request wins.
//   Ports:
//     i_req        per-requester request vector
//     i_rr_ptr     index of the most recently granted requester
//     o_grant      one-hot grant (all zero when nothing requests)
//     o_grant_idx  binary index of the granted requester
//     o_any        at least one request is present
// ---------------------------------------------------------------------------
module fpu_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_rr_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_idx;
    int unsigned     w_ptr;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_idx       = '0;
        w_ptr       = 32'(i_rr_ptr);
        // k = 1..NUM_REQ visits every index once, ending at rr_ptr itself.
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            w_idx = ID_W'((w_ptr + k) % NUM_REQ);
            if (!o_any && i_req[w_idx]) begin
                o_any          = 1'b1;
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx;
            end
        end
    end

endmodule

// File: rtl/fpu_arbiter.sv
// ---------------------------------------------------------------------------
// fpu_arbiter
//   Shares one FPU add/sub datapath between NUM_REQ requesters. Requests are
//   granted round-robin, operands latched, the FPU is cleared for one cycle
//   and then run until it reports done or TIMEOUT_CYCLES expire. The result
//   is returned on a valid/ready response channel.
//   Ports:
//     clock, reset               clock, asynchronous active-high reset
//     req_valid/ready            per-requester request handshake
//     req_op_a/op_b/sub          packed 32-bit operands, subtract flag
//     rsp_valid/ready            response handshake
//     rsp_id/data/status/timeout response payload
//     fpu_reset_n                active-low clear to the FPU
//     fpu_op_a/op_b              operands to the FPU
//     fpu_data_in/status_in      FPU result and status (bit0 = done)
// ---------------------------------------------------------------------------
module fpu_arbiter
    import fpu_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = 2,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_op_a,
    input  logic [32*NUM_REQ-1:0] req_op_b,
    input  logic [NUM_REQ-1:0]    req_sub,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_data,
    output logic [3:0]            rsp_status,
    output logic                  rsp_timeout,
    output logic                  fpu_reset_n,
    output logic [31:0]           fpu_op_a,
    output logic [31:0]           fpu_op_b,
    input  logic [31:0]           fpu_data_in,
    input  logic [3:0]            fpu_status_in
);

    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 0) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    arb_state_t       r_state;
    logic [ID_W-1:0]  r_rr_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic [ID_W-1:0]  r_id;
    logic             r_rsp_valid;
    logic [31:0]      r_rsp_data;
    logic [3:0]       r_rsp_status;
    logic             r_rsp_timeout;
    logic             r_fpu_reset_n;
    logic [31:0]      r_op_a;
    logic [31:0]      r_op_b;

    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_grant_idx;
    logic               w_any;
    logic [31:0]        w_sel_a;
    logic [31:0]        w_sel_b;
    logic               w_sel_sub;

    fpu_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr (
        .i_req       (req_valid),
        .i_rr_ptr    (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_sub = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a   = req_op_a[32*i +: 32];
                w_sel_b   = req_op_b[32*i +: 32];
                w_sel_sub = req_sub[i];
            end
        end
    end

    // Accept is combinational in IDLE; gated by reset so nothing is accepted
    // while the controller is held in reset.
    assign req_ready = (r_state == IDLE && !reset) ? w_grant : '0;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= IDLE;
            r_rr_ptr      <= ID_W'(NUM_REQ - 1);
            r_cnt         <= '0;
            r_id          <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_status  <= ST_NONE;
            r_rsp_timeout <= 1'b0;
            r_fpu_reset_n <= 1'b0;
            r_op_a        <= '0;
            r_op_b        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_fpu_reset_n <= 1'b0;
                    if (w_any) begin
                        r_op_a   <= w_sel_a;
                        r_op_b   <= {w_sel_b[SIGN_BIT] ^ w_sel_sub, w_sel_b[SIGN_BIT-1:0]};
                        r_id     <= w_grant_idx;
                        r_rr_ptr <= w_grant_idx;
                        r_state  <= CLEAR;
                    end
                end
                CLEAR: begin
                    r_cnt         <= '0;
                    r_fpu_reset_n <= 1'b1;
                    r_state       <= RUN;
                end
                RUN: begin
                    if (fpu_status_in[0]) begin
                        r_state <= SETTLE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_rsp_data    <= '0;
                        r_rsp_status  <= ST_NONE;
                        r_rsp_timeout <= 1'b1;
                        r_rsp_valid   <= 1'b1;
                        r_state       <= RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                SETTLE: begin
                    // Data lags status by one cycle, so capture here.
                    r_rsp_data    <= fpu_data_in;
                    r_rsp_status  <= fpu_status_in;
                    r_rsp_timeout <= 1'b0;
                    r_rsp_valid   <= 1'b1;
                    r_state       <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_rsp_valid   <= 1'b0;
                        r_fpu_reset_n <= 1'b0;
                        r_state       <= IDLE;
                    end
                end
                default: begin
                    r_fpu_reset_n <= 1'b0;
                    r_rsp_valid   <= 1'b0;
                    r_state       <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid   = r_rsp_valid;
    assign rsp_id      = r_id;
    assign rsp_data    = r_rsp_data;
    assign rsp_status  = r_rsp_status;
    assign rsp_timeout = r_rsp_timeout;
    assign fpu_reset_n = r_fpu_reset_n;
    assign fpu_op_a    = r_op_a;
    assign fpu_op_b    = r_op_b;

endmodule
